m_pcpi_initiator: RTL and testbench
===================================

Name: m_pcpi_initiator

Overview:
- Core-side PCPI initiator; the counterpart of the M-extension coprocessor responder.
- Accepts one co-processor instruction from the core's execute stage and drives PCPI valid/insn/rs1/rs2.
- Waits for the responder's ready/wr/rd and returns the result to the core's writeback through a valid/ready response buffer.
- Enforces an illegal-instruction timeout when no responder claims the instruction.

Parameters:
- TIMEOUT_CYCLES, 16: consecutive unclaimed ISSUE cycles before the instruction is declared illegal; legal range 1..255.
- LAT_W, 16: width of the latency counter reported with each response.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- req_valid  in  1  core presents an instruction.
- req_ready  out  1  initiator can accept a request.
- req_instr  in  32  instruction word.
- req_rs1  in  32  operand 1.
- req_rs2  in  32  operand 2.
- pcpi_valid  out  1  instruction offered to the co-processor.
- pcpi_insn  out  32  latched instruction.
- pcpi_rs1  out  32  latched operand 1.
- pcpi_rs2  out  32  latched operand 2.
- pcpi_wr  in  1  responder writes rd.
- pcpi_rd  in  32  responder result.
- pcpi_busy  in  1  responder claimed the instruction and is working.
- pcpi_ready  in  1  responder result valid, single-cycle pulse.
- resp_valid  out  1  response available.
- resp_ready  in  1  writeback accepts the response.
- resp_wr  out  1  write rd.
- resp_rd  out  32  result.
- resp_illegal  out  1  timeout; no responder claimed the instruction.
- resp_cycles  out  LAT_W  ISSUE-state cycles spent, saturating.

Behaviour:
- Reset (async, resetn=0): state IDLE, all outputs 0, counters 0. This applies mid-transaction: pcpi_valid drops immediately and the pending request is discarded without a response.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid: latch instr/rs1/rs2, clear the timeout counter, the claimed flag and the latency counter.
  - Go to ISSUE; pcpi_valid=1 from the next cycle.
- ISSUE:
  - req_ready=0. pcpi_valid=1. pcpi_insn/rs1/rs2 stable for the whole state.
  - Each ISSUE cycle increments the latency counter, saturating at 2^LAT_W-1.
  - pcpi_ready=1: capture pcpi_wr into resp_wr and pcpi_rd into resp_rd; resp_illegal=0; go to RESP. pcpi_valid is 0 on the following cycle.
  - Else if pcpi_busy=1: set claimed (sticky for this transaction); clear the timeout counter.
  - Else if claimed=0: increment the timeout counter. When it equals TIMEOUT_CYCLES after the increment, go to RESP with resp_illegal=1, resp_wr=0, resp_rd=0.
  - Else (claimed=1, busy=0, ready=0): no timeout; keep waiting indefinitely.
  - pcpi_ready wins over the timeout in the same cycle.
  - resp_cycles = latency counter value including the ready/timeout cycle.
- RESP:
  - resp_valid=1. resp_wr/resp_rd/resp_illegal/resp_cycles held stable.
  - pcpi_ready/pcpi_busy are ignored; a spurious ready is dropped.
  - On resp_ready: go to IDLE; resp_valid=0 next cycle. There is no IDLE bypass, so back-to-back requests cost one idle cycle.
- Latency: request accept to pcpi_valid is 1 cycle. pcpi_ready to resp_valid is 1 cycle.
- pcpi_rd is captured only when pcpi_ready=1; its value at any other time is don't-care.

Decomposition:
- Shared package m_pcpi_pkg: state enum (IDLE/ISSUE/RESP), TIMEOUT_CYCLES default constant, response struct {wr, rd, illegal, cycles}.
- One natural sub-module: m_pcpi_watchdog, containing the timeout counter, claimed flag and saturating latency counter.
  - Inputs: start, active, busy, ready.
  - Outputs: timeout, cycles.
- FSM and operand/response registers stay in the top module.

Test Plan:
- MUL: rs1=7, rs2=6, responder asserts busy at issue cycles 1–2 and ready with rd=42, wr=1 at cycle 3 -> resp_valid cycle 4 with resp_rd=42, resp_wr=1, resp_illegal=0, resp_cycles=3; pcpi_valid low on cycle 4.
- No responder, TIMEOUT_CYCLES=16 -> resp_illegal=1, resp_wr=0, resp_rd=0, resp_cycles=16; pcpi_valid high for exactly 16 cycles.
- Long DIV: busy asserted at cycle 1, held 40 cycles, then ready rd=0xFFFFFFFF wr=1 -> no timeout; resp_rd=0xFFFFFFFF, resp_cycles=41.
- Backpressure: resp_ready=0 for 5 cycles after resp_valid -> response fields stable; req_ready=0; a new req_valid is not accepted until 1 cycle after the handshake.
- Boundary: ready and timeout both on cycle 16 with rd=5 -> resp_illegal=0, resp_rd=5. Then resetn pulsed low mid-ISSUE -> pcpi_valid=0 and resp_valid=0 immediately; next request proceeds normally.

Source files
------------

// File: rtl/m_pcpi_initiator_pkg.sv
// Shared types for the PCPI initiator: FSM states, default timeout and the response record.
// Latency/backpressure: none (declarations only).
package m_pcpi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  localparam int TIMEOUT_CYCLES_DEF = 16;
  localparam int LAT_W_MAX          = 32;

  // cycles is sized for the widest supported latency counter; narrower builds zero-extend.
  typedef struct packed {
    logic                 wr;
    logic [31:0]          rd;
    logic                 illegal;
    logic [LAT_W_MAX-1:0] cycles;
  } resp_t;

endpackage

// File: rtl/m_pcpi_initiator_if.sv
// Request, PCPI and response signals of the initiator; master is the initiator's view.
// Latency/backpressure: none (wiring only).
interface m_pcpi_initiator_if #(
  parameter int LAT_W = 16
);
  logic             req_valid;
  logic             req_ready;
  logic [31:0]      req_instr;
  logic [31:0]      req_rs1;
  logic [31:0]      req_rs2;
  logic             pcpi_valid;
  logic [31:0]      pcpi_insn;
  logic [31:0]      pcpi_rs1;
  logic [31:0]      pcpi_rs2;
  logic             pcpi_wr;
  logic [31:0]      pcpi_rd;
  logic             pcpi_busy;
  logic             pcpi_ready;
  logic             resp_valid;
  logic             resp_ready;
  logic             resp_wr;
  logic [31:0]      resp_rd;
  logic             resp_illegal;
  logic [LAT_W-1:0] resp_cycles;

  modport master (
    input  req_valid, req_instr, req_rs1, req_rs2,
    output req_ready,
    output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    input  pcpi_wr, pcpi_rd, pcpi_busy, pcpi_ready,
    output resp_valid, resp_wr, resp_rd, resp_illegal, resp_cycles,
    input  resp_ready
  );

  modport slave (
    output req_valid, req_instr, req_rs1, req_rs2,
    input  req_ready,
    input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    output pcpi_wr, pcpi_rd, pcpi_busy, pcpi_ready,
    input  resp_valid, resp_wr, resp_rd, resp_illegal, resp_cycles,
    output resp_ready
  );
endinterface

// File: rtl/m_pcpi_initiator_watchdog.sv
// Unclaimed-instruction timeout and saturating ISSUE latency counter; timeout/cycles are combinational
// views of the current ISSUE cycle. No backpressure: start clears, active advances.
module m_pcpi_watchdog #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int LAT_W          = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             active,
  input  logic             busy,
  input  logic             ready,
  output logic             timeout,
  output logic [LAT_W-1:0] cycles
);
  localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYCLES);

  logic [7:0]       tcnt;
  logic             claimed;
  logic [LAT_W-1:0] lat;
  logic [LAT_W-1:0] lat_inc;

  always_comb begin
    lat_inc = (&lat) ? lat : lat + LAT_W'(1);
    cycles  = active ? lat_inc : lat;
    // A claimed instruction never times out; ready in the same cycle takes priority.
    timeout = active && !ready && !busy && !claimed && ((tcnt + 8'd1) == TO_LIM);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tcnt    <= '0;
      claimed <= 1'b0;
      lat     <= '0;
    end else if (start) begin
      tcnt    <= '0;
      claimed <= 1'b0;
      lat     <= '0;
    end else if (active) begin
      lat <= lat_inc;
      if (!ready) begin
        if (busy) begin
          claimed <= 1'b1;
          tcnt    <= '0;
        end else if (!claimed) begin
          tcnt <= tcnt + 8'd1;
        end
      end
    end
  end
endmodule

// File: rtl/m_pcpi_initiator.sv
// Core-side PCPI initiator: accept -> pcpi_valid 1 cycle, pcpi_ready/timeout -> resp_valid 1 cycle.
// One transaction in flight; resp_valid holds until resp_ready, req_ready returns one cycle later.
module m_pcpi_initiator
  import m_pcpi_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int LAT_W          = 16
) (
  input  logic               clk,
  input  logic               resetn,
  m_pcpi_initiator_if.master bus
);
  state_t               state;
  resp_t                resp_q;
  logic                 accept;
  logic                 wd_timeout;
  logic [LAT_W-1:0]     wd_cycles;
  logic [LAT_W_MAX-1:0] cyc_ext;
  logic                 unused_cyc_hi;

  assign accept = (state == IDLE) && bus.req_valid && bus.req_ready;

  m_pcpi_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .LAT_W         (LAT_W)
  ) u_watchdog (
    .clk    (clk),
    .resetn (resetn),
    .start  (accept),
    .active (state == ISSUE),
    .busy   (bus.pcpi_busy),
    .ready  (bus.pcpi_ready),
    .timeout(wd_timeout),
    .cycles (wd_cycles)
  );

  always_comb begin
    cyc_ext              = '0;
    cyc_ext[LAT_W-1:0]   = wd_cycles;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= IDLE;
      bus.req_ready  <= 1'b0;
      bus.pcpi_valid <= 1'b0;
      bus.pcpi_insn  <= '0;
      bus.pcpi_rs1   <= '0;
      bus.pcpi_rs2   <= '0;
      bus.resp_valid <= 1'b0;
      resp_q         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            bus.pcpi_insn  <= bus.req_instr;
            bus.pcpi_rs1   <= bus.req_rs1;
            bus.pcpi_rs2   <= bus.req_rs2;
            bus.pcpi_valid <= 1'b1;
            bus.req_ready  <= 1'b0;
            state          <= ISSUE;
          end else begin
            bus.req_ready  <= 1'b1;
          end
        end
        ISSUE: begin
          if (bus.pcpi_ready) begin
            resp_q         <= '{wr: bus.pcpi_wr, rd: bus.pcpi_rd, illegal: 1'b0, cycles: cyc_ext};
            bus.pcpi_valid <= 1'b0;
            bus.resp_valid <= 1'b1;
            state          <= RESP;
          end else if (wd_timeout) begin
            resp_q         <= '{wr: 1'b0, rd: 32'd0, illegal: 1'b1, cycles: cyc_ext};
            bus.pcpi_valid <= 1'b0;
            bus.resp_valid <= 1'b1;
            state          <= RESP;
          end
        end
        RESP: begin
          // Late ready/busy from the responder is deliberately ignored here.
          if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            bus.req_ready  <= 1'b1;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.resp_wr      = resp_q.wr;
  assign bus.resp_rd      = resp_q.rd;
  assign bus.resp_illegal = resp_q.illegal;
  assign bus.resp_cycles  = resp_q.cycles[LAT_W-1:0];
  assign unused_cyc_hi    = ^resp_q.cycles;
endmodule

// File: tb/tb_m_pcpi_initiator.sv
// Directed bench for m_pcpi_initiator: stimulus pushes expected responses, a negedge monitor checks them.
module tb_m_pcpi_initiator;
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  m_pcpi_initiator_if #(.LAT_W(16)) bus ();

  m_pcpi_initiator #(
    .TIMEOUT_CYCLES(16),
    .LAT_W         (16)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  typedef struct {
    logic        wr;
    logic [31:0] rd;
    logic        illegal;
    logic [15:0] cycles;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every cycle a response is presented it must match the queue head; pop on handshake.
  always @(negedge clk) begin
    if (resetn === 1'b1 && bus.resp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("spurious_resp", 1, 0);
      end else begin
        chk("resp_wr",      bus.resp_wr,      exp_q[0].wr);
        chk("resp_rd",      bus.resp_rd,      exp_q[0].rd);
        chk("resp_illegal", bus.resp_illegal, exp_q[0].illegal);
        chk("resp_cycles",  bus.resp_cycles,  exp_q[0].cycles);
        if (bus.resp_ready === 1'b1) void'(exp_q.pop_front());
      end
    end
  end

  task automatic run_txn(input string name, input logic [31:0] instr, input logic [31:0] a,
                         input logic [31:0] b, input int busy_lo, input int busy_hi,
                         input int ready_at, input logic [31:0] rd, input logic wr,
                         input int exp_hi, output int waited);
    int k;
    bus.req_valid = 1'b1;
    bus.req_instr = instr;
    bus.req_rs1   = a;
    bus.req_rs2   = b;
    waited = 0;
    while (bus.req_ready !== 1'b1 && waited < 50) begin
      step();
      waited++;
    end
    chk({name, "_req_ready"}, bus.req_ready, 1);
    step();
    bus.req_valid = 1'b0;
    k = 1;
    while (bus.pcpi_valid === 1'b1 && k <= 300) begin
      chk({name, "_operands"}, {bus.pcpi_insn, bus.pcpi_rs1, bus.pcpi_rs2}, {instr, a, b});
      bus.pcpi_busy  = (k >= busy_lo && k <= busy_hi);
      bus.pcpi_ready = (k == ready_at);
      bus.pcpi_rd    = (k == ready_at) ? rd : 32'hDEAD_BEEF;
      bus.pcpi_wr    = (k == ready_at) ? wr : 1'b1;
      step();
      k++;
    end
    bus.pcpi_busy  = 1'b0;
    bus.pcpi_ready = 1'b0;
    chk({name, "_valid_cycles"}, k - 1, exp_hi);
    chk({name, "_resp_latency"}, bus.resp_valid, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete, got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int w;
    resetn         = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_instr  = '0;
    bus.req_rs1    = '0;
    bus.req_rs2    = '0;
    bus.pcpi_wr    = 1'b0;
    bus.pcpi_rd    = '0;
    bus.pcpi_busy  = 1'b0;
    bus.pcpi_ready = 1'b0;
    bus.resp_ready = 1'b1;
    #12;
    chk("rst_req_ready",  bus.req_ready, 0);
    chk("rst_pcpi_valid", bus.pcpi_valid, 0);
    chk("rst_operands",   {bus.pcpi_insn, bus.pcpi_rs1, bus.pcpi_rs2}, 0);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_resp_flds",  {bus.resp_wr, bus.resp_rd, bus.resp_illegal, bus.resp_cycles}, 0);
    step();
    resetn = 1'b1;
    step();

    // MUL 7*6: busy on cycles 1-2, ready on 3.
    exp_q.push_back('{wr: 1'b1, rd: 32'd42, illegal: 1'b0, cycles: 16'd3});
    run_txn("mul", 32'h0273_02B3, 32'd7, 32'd6, 1, 2, 3, 32'd42, 1'b1, 3, w);
    step();

    // Nobody claims: illegal after 16 cycles, rd/wr forced to zero.
    exp_q.push_back('{wr: 1'b0, rd: 32'd0, illegal: 1'b1, cycles: 16'd16});
    run_txn("timeout", 32'h0000_000B, 32'h1111_1111, 32'h2222_2222, 1, 0, 0, 32'd0, 1'b0, 16, w);
    step();

    // Long DIV: claimed on cycle 1, busy through 40, ready on 41.
    exp_q.push_back('{wr: 1'b1, rd: 32'hFFFF_FFFF, illegal: 1'b0, cycles: 16'd41});
    run_txn("div", 32'h0273_42B3, 32'd100, 32'd0, 1, 40, 41, 32'hFFFF_FFFF, 1'b1, 41, w);
    step();

    // Backpressure: hold resp_ready low 5 cycles with a new request waiting and a stray ready.
    bus.resp_ready = 1'b0;
    exp_q.push_back('{wr: 1'b1, rd: 32'd3, illegal: 1'b0, cycles: 16'd2});
    run_txn("bp_a", 32'h0273_52B3, 32'd10, 32'd3, 1, 1, 2, 32'd3, 1'b1, 2, w);
    bus.req_valid = 1'b1;
    bus.req_instr = 32'h0273_02B3;
    bus.req_rs1   = 32'h0000_1234;
    bus.req_rs2   = 32'd1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_req_ready",  bus.req_ready, 0);
      chk("bp_resp_valid", bus.resp_valid, 1);
      bus.pcpi_ready = (i == 2);
      bus.pcpi_rd    = 32'd99;
      bus.pcpi_wr    = 1'b0;
      step();
    end
    bus.pcpi_ready = 1'b0;
    bus.resp_ready = 1'b1;
    exp_q.push_back('{wr: 1'b0, rd: 32'h0000_1234, illegal: 1'b0, cycles: 16'd1});
    run_txn("bp_b", 32'h0273_02B3, 32'h0000_1234, 32'd1, 1, 0, 1, 32'h0000_1234, 1'b0, 1, w);
    chk("bp_accept_wait", w, 1);
    step();

    // Ready and timeout coincide on cycle 16: ready wins.
    exp_q.push_back('{wr: 1'b1, rd: 32'd5, illegal: 1'b0, cycles: 16'd16});
    run_txn("boundary", 32'h0273_62B3, 32'd25, 32'd5, 1, 0, 16, 32'd5, 1'b1, 16, w);
    step();

    // Async reset in the middle of ISSUE discards the transaction.
    bus.req_valid = 1'b1;
    bus.req_instr = 32'h0273_02B3;
    bus.req_rs1   = 32'd9;
    bus.req_rs2   = 32'd9;
    w = 0;
    while (bus.req_ready !== 1'b1 && w < 50) begin
      step();
      w++;
    end
    step();
    bus.req_valid = 1'b0;
    bus.pcpi_busy = 1'b1;
    step();
    step();
    chk("pre_rst_pcpi_valid", bus.pcpi_valid, 1);
    resetn = 1'b0;
    #1;
    chk("mid_rst_pcpi_valid", bus.pcpi_valid, 0);
    chk("mid_rst_resp_valid", bus.resp_valid, 0);
    chk("mid_rst_req_ready",  bus.req_ready, 0);
    bus.pcpi_busy = 1'b0;
    step();
    resetn = 1'b1;
    step();

    exp_q.push_back('{wr: 1'b1, rd: 32'd15, illegal: 1'b0, cycles: 16'd1});
    run_txn("post_rst", 32'h0273_02B3, 32'd3, 32'd5, 1, 0, 1, 32'd15, 1'b1, 1, w);
    step();
    step();
    step();
    chk("queue_drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
